node_select_fsm: RTL and testbench



---
 rtl/node_select_fsm_if.sv | 25 ++
 rtl/node_select_fsm.sv | 159 +++++++++++++++
 tb/tb_node_select_fsm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/node_select_fsm_if.sv
// Switch/key front-end bundle for node_select_fsm: control pulses, switch value, results and HEX digits.
interface node_select_fsm_if #(
  parameter int NODE_W  = 5,
  parameter int NUM_SEL = 2
);
  logic                      start;
  logic                      ld;
  logic [NODE_W-1:0]         data_in;
  logic [NODE_W-1:0]         num_nodes;
  logic                      busy;
  logic                      done;
  logic [NUM_SEL*NODE_W-1:0] sel_nodes;
  logic [3:0]                err_count;
  logic [6:0]                h0, h1, h2, h3, h4, h5;

  modport master (
    output start, ld, data_in, num_nodes,
    input  busy, done, sel_nodes, err_count, h0, h1, h2, h3, h4, h5
  );

  modport slave (
    input  start, ld, data_in, num_nodes,
    output busy, done, sel_nodes, err_count, h0, h1, h2, h3, h4, h5
  );
endinterface

// File: rtl/node_select_fsm.sv
// Collects NUM_SEL range-checked node indices, one per ld, with HEX prompts/echo/error banner.
// Accept/reject decided 2 cycles after ld; NODE_SEL_DISTINCT_EN also rejects repeated indices.
module node_select_fsm #(
  parameter int NODE_W   = 5,
  parameter int NUM_SEL  = 2,
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  node_select_fsm_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PROMPT   = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] SHOW_ERR = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [3:0]  LAST_SLOT = 4'(NUM_SEL - 1);
  localparam logic [31:0] HOLD_LD   = 32'(HOLD_CYC - 1);

  localparam logic [6:0] SEG_C = 7'b1000110, SEG_H = 7'b0001001, SEG_O = 7'b1000000;
  localparam logic [6:0] SEG_S = 7'b0010010, SEG_E = 7'b0000110, SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_I = 7'b1111001, SEG_N = 7'b0101011, SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_A = 7'b0001000, SEG_D = 7'b0100001, SEG_P = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [41:0] MSG_CHOOSE = {SEG_C, SEG_H, SEG_O, SEG_O, SEG_S, SEG_E};
  localparam logic [41:0] MSG_INVALD = {SEG_I, SEG_N, SEG_U, SEG_A, SEG_L, SEG_D};
  localparam logic [41:0] MSG_DUP    = {SEG_D, SEG_U, SEG_P, SEG_BLANK, SEG_BLANK, SEG_BLANK};

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  logic [2:0]                state, state_n;
  logic [3:0]                slot, slot_n;
  logic [NODE_W-1:0]         cand, cand_n;
  logic [NUM_SEL*NODE_W-1:0] sel, sel_n;
  logic [3:0]                errc, errc_n;
  logic [31:0]               hold, hold_n;
  logic                      dup, dup_n;
  logic                      in_range, is_dup;
  logic [41:0]               hex, hex_n;
  logic                      busy_r, done_r;
  logic [6:0]                din7;
  logic [3:0]                tens, ones;

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    cand_n   = cand;
    sel_n    = sel;
    errc_n   = errc;
    hold_n   = hold;
    dup_n    = dup;
    in_range = (cand < bus.num_nodes);
    is_dup   = 1'b0;
`ifdef NODE_SEL_DISTINCT_EN
    for (int k = 0; k < NUM_SEL; k++) begin
      if ((4'(k) < slot) && (sel[k*NODE_W +: NODE_W] == cand)) is_dup = 1'b1;
    end
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = PROMPT;
          slot_n  = 4'd0;
          sel_n   = '0;
          errc_n  = 4'd0;
        end
      end
      PROMPT: begin
        if (bus.ld) begin
          cand_n  = bus.data_in;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (in_range && !is_dup) begin
          sel_n[slot*NODE_W +: NODE_W] = cand;
          if (slot == LAST_SLOT) begin
            state_n = DONE;
          end else begin
            slot_n  = slot + 4'd1;
            state_n = PROMPT;
          end
        end else begin
          if (errc != 4'd15) errc_n = errc + 4'd1;
          hold_n  = HOLD_LD;
          // An invalid candidate that passed the range check can only have failed as a duplicate.
          dup_n   = in_range;
          state_n = SHOW_ERR;
        end
      end
      SHOW_ERR: begin
        if (hold == 32'd0) state_n = PROMPT;
        else               hold_n  = hold - 32'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // HEX digits are decoded from next-state values so the registered display tracks the state.
  always_comb begin
    din7 = 7'(bus.data_in);
    tens = 4'(din7 / 7'd10);
    ones = 4'(din7 % 7'd10);
    case (state_n)
      PROMPT, CHECK: hex_n = {SEG_S, SEG_E, SEG_L, seg_digit(slot_n), seg_digit(tens), seg_digit(ones)};
      SHOW_ERR:      hex_n = dup_n ? MSG_DUP : MSG_INVALD;
      default:       hex_n = MSG_CHOOSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      slot   <= 4'd0;
      cand   <= '0;
      sel    <= '0;
      errc   <= 4'd0;
      hold   <= 32'd0;
      dup    <= 1'b0;
      hex    <= MSG_CHOOSE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      slot   <= slot_n;
      cand   <= cand_n;
      sel    <= sel_n;
      errc   <= errc_n;
      hold   <= hold_n;
      dup    <= dup_n;
      hex    <= hex_n;
      busy_r <= (state_n != IDLE);
      done_r <= (state_n == DONE);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sel_nodes = sel;
  assign bus.err_count = errc;
  assign {bus.h5, bus.h4, bus.h3, bus.h2, bus.h1, bus.h0} = hex;
endmodule

// File: tb/tb_node_select_fsm.sv
// Directed bench for node_select_fsm (NODE_W=5, NUM_SEL=2, HOLD_CYC=4) with hand-computed expectations.
module tb_node_select_fsm;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  node_select_fsm_if #(.NODE_W(5), .NUM_SEL(2)) bus ();

  node_select_fsm #(.NODE_W(5), .NUM_SEL(2), .HOLD_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [41:0] CHOOSE = {7'b1000110, 7'b0001001, 7'b1000000, 7'b1000000, 7'b0010010, 7'b0000110};
  localparam logic [41:0] INVALD = {7'b1111001, 7'b0101011, 7'b1000001, 7'b0001000, 7'b1000111, 7'b0100001};
  localparam logic [41:0] DUPMSG = {7'b0100001, 7'b1000001, 7'b0001100, 7'b1111111, 7'b1111111, 7'b1111111};
  localparam logic [20:0] SEL    = {7'b0010010, 7'b0000110, 7'b1000111};
  localparam logic [6:0]  DIG0 = 7'b1000000, DIG1 = 7'b1111001, DIG7 = 7'b1111000;

  logic [41:0] hex_all;
  assign hex_all = {bus.h5, bus.h4, bus.h3, bus.h2, bus.h1, bus.h0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // ld pulse then the CHECK cycle: returns at ld+2, where accept/reject is visible.
  task automatic load(input logic [4:0] v);
    bus.data_in = v;
    bus.ld      = 1'b1;
    tick();
    bus.ld      = 1'b0;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.ld        = 1'b0;
    bus.data_in   = 5'd17;
    bus.num_nodes = 5'd6;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sel", 64'(bus.sel_nodes), 64'd0);
    check("rst_err", 64'(bus.err_count), 64'd0);
    check("rst_hex", 64'(hex_all), 64'(CHOOSE));

    // Basic session: echo of 17, then 3 and 5 accepted.
    pulse_start();
    check("prompt_busy", 64'(bus.busy), 64'd1);
    check("prompt_hex", 64'(hex_all), 64'({SEL, DIG0, DIG1, DIG7}));
    load(5'd3);
    check("acc1_done", 64'(bus.done), 64'd0);
    check("acc1_slot", 64'(bus.h2), 64'(DIG1));
    load(5'd5);
    check("acc2_done", 64'(bus.done), 64'd1);
    check("acc2_busy", 64'(bus.busy), 64'd1);
    check("acc2_sel", 64'(bus.sel_nodes), 64'd163);
    check("acc2_err", 64'(bus.err_count), 64'd0);
    tick();
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_hex", 64'(hex_all), 64'(CHOOSE));
    check("idle_sel_hold", 64'(bus.sel_nodes), 64'd163);

    // Out-of-range entry, ld ignored in the banner, start ignored in PROMPT.
    pulse_start();
    check("new_sess_sel", 64'(bus.sel_nodes), 64'd0);
    load(5'd6);
    check("rej_hex", 64'(hex_all), 64'(INVALD));
    check("rej_err", 64'(bus.err_count), 64'd1);
    bus.data_in = 5'd1;
    bus.ld      = 1'b1;
    tick();
    bus.ld      = 1'b0;
    tick();
    tick();
    check("rej_hold4", 64'(hex_all), 64'(INVALD));
    bus.data_in = 5'd0;
    tick();
    check("rej_back", 64'(hex_all), 64'({SEL, DIG0, DIG0, DIG0}));
    pulse_start();
    check("start_ign_err", 64'(bus.err_count), 64'd1);
    check("start_ign_slot", 64'(bus.h2), 64'(DIG0));
    load(5'd0);
    check("acc0_slot", 64'(bus.h2), 64'(DIG1));
    load(5'd4);
    check("acc0_done", 64'(bus.done), 64'd1);
    check("acc0_sel", 64'(bus.sel_nodes), 64'd128);
    tick();

    // Duplicate entry.
    pulse_start();
    load(5'd2);
    load(5'd2);
`ifdef NODE_SEL_DISTINCT_EN
    check("dup_hex", 64'(hex_all), 64'(DUPMSG));
    check("dup_err", 64'(bus.err_count), 64'd1);
    tick();
    tick();
    tick();
    tick();
    load(5'd3);
    check("dup_done", 64'(bus.done), 64'd1);
    check("dup_sel", 64'(bus.sel_nodes), 64'd98);
`else
    check("dup_done", 64'(bus.done), 64'd1);
    check("dup_sel", 64'(bus.sel_nodes), 64'd66);
    check("dup_err", 64'(bus.err_count), 64'd0);
    check("dup_hex_unused", 64'(hex_all == DUPMSG), 64'd0);
`endif
    tick();

    // num_nodes = 0 rejects everything; saturation at 15; reset inside the banner.
    bus.num_nodes = 5'd0;
    pulse_start();
    for (int i = 1; i <= 17; i++) begin
      load((i == 1) ? 5'd0 : 5'd31);
      if (i == 1)  check("zero_nodes_err", 64'(bus.err_count), 64'd1);
      if (i == 15) check("err_15", 64'(bus.err_count), 64'd15);
      if (i == 16) check("err_sat16", 64'(bus.err_count), 64'd15);
      if (i < 17) begin
        tick();
        tick();
        tick();
        tick();
      end
    end
    check("err_sat17", 64'(bus.err_count), 64'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_err", 64'(bus.err_count), 64'd0);
    check("mid_rst_sel", 64'(bus.sel_nodes), 64'd0);
    check("mid_rst_hex", 64'(hex_all), 64'(CHOOSE));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_nodone", 64'(bus.done), 64'd0);
    end

    // start and ld together in IDLE: ld is dropped.
    bus.num_nodes = 5'd6;
    bus.data_in   = 5'd1;
    bus.start     = 1'b1;
    bus.ld        = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.ld        = 1'b0;
    tick();
    tick();
    check("start_ld_busy", 64'(bus.busy), 64'd1);
    check("start_ld_hex", 64'(hex_all), 64'({SEL, DIG0, DIG0, DIG1}));
    check("start_ld_sel", 64'(bus.sel_nodes), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
